// File: rtl/proc_zbt_writer_if.sv
// Shared ZBT bank 1 port: display read request in, registered address,
// write enable and delayed write data out.
interface proc_zbt_writer_if;
    logic        rd_req;
    logic [18:0] rd_addr;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [35:0] mem_write_data;

    modport master (
        input  rd_req,
        input  rd_addr,
        output mem_addr,
        output mem_we,
        output mem_write_data
    );

    modport slave (
        output rd_req,
        output rd_addr,
        input  mem_addr,
        input  mem_we,
        input  mem_write_data
    );
endinterface

// File: rtl/proc_zbt_writer.sv
// Queues processed pixel pairs and writes them to ZBT bank 1 in cycles
// the display reader leaves idle; write data trails mem_we by two cycles.
module proc_zbt_writer #(
    parameter int DEPTH    = 4,
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [10:0]              hcount,
    input  logic [9:0]               vcount,
    input  logic [35:0]              two_proc_pixs,
    input  logic [18:0]              proc_pix_addr,
    input  logic                     wr_enable,
    proc_zbt_writer_if.master        zbt,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE = (AW + 1)'(1);

    logic [18:0] addr_q [DEPTH];
    logic [35:0] data_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [35:0] d1;
    logic [35:0] d2;
    logic        v1;
    logic        v2;

    logic push;
    logic pop;
    logic full;
    logic accept;

    assign push = wr_enable & hcount[0]
                & ({1'b0, hcount} < H_LIM)
                & ({1'b0, vcount} < V_LIM);
    assign full = (fifo_level == FULL_LVL);
    assign pop = ~zbt.rd_req & (fifo_level != '0);
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign accept = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q[wr_ptr] <= proc_pix_addr;
            data_q[wr_ptr] <= two_proc_pixs;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({accept, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
            if (push & full & ~pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zbt.mem_addr <= '0;
            zbt.mem_we   <= 1'b0;
        end else begin
            unique case (1'b1)
                zbt.rd_req: begin
                    zbt.mem_addr <= zbt.rd_addr;
                    zbt.mem_we   <= 1'b0;
                end
                pop: begin
                    zbt.mem_addr <= addr_q[rd_ptr];
                    zbt.mem_we   <= 1'b1;
                end
                default: zbt.mem_we <= 1'b0;
            endcase
        end
    end

    // Two-stage delay so data lands on the bus two cycles after mem_we.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1                 <= '0;
            d2                 <= '0;
            v1                 <= 1'b0;
            v2                 <= 1'b0;
            zbt.mem_write_data <= '0;
        end else begin
            v1 <= pop;
            v2 <= v1;
            if (pop)
                d1 <= data_q[rd_ptr];
            d2 <= d1;
            if (v2)
                zbt.mem_write_data <= d2;
        end
    end
endmodule

// File: tb/tb_proc_zbt_writer.sv
// Directed bench for proc_zbt_writer: queue-based model checked every
// cycle on the falling edge, plus hand-computed literal expectations.
module tb_proc_zbt_writer;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [35:0] two_proc_pixs;
    logic [18:0] proc_pix_addr;
    logic        wr_enable;
    logic [2:0]  fifo_level;
    logic        overflow;

    proc_zbt_writer_if bus ();

    proc_zbt_writer dut (
        .clk           (clk),
        .reset         (reset),
        .hcount        (hcount),
        .vcount        (vcount),
        .two_proc_pixs (two_proc_pixs),
        .proc_pix_addr (proc_pix_addr),
        .wr_enable     (wr_enable),
        .zbt           (bus.master),
        .fifo_level    (fifo_level),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run = 1'b1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [18:0] a;
        logic [35:0] d;
    } entry_t;
    typedef struct {
        int          t;
        logic [35:0] d;
    } due_t;

    entry_t      q[$];
    due_t        due[$];
    int          cyc = 0;
    logic [18:0] e_addr = '0;
    logic        e_we = 1'b0;
    logic [35:0] e_wdata = '0;
    logic        e_ovf = 1'b0;

    // Model: queue of captured pairs; reads win, otherwise pop the oldest.
    always @(posedge clk) begin
        entry_t h;
        bit     p;
        if (reset) begin
            q.delete();
            due.delete();
            e_addr  = '0;
            e_we    = 1'b0;
            e_wdata = '0;
            e_ovf   = 1'b0;
        end else begin
            p = wr_enable && hcount[0] && hcount < 1024 && vcount < 768;
            if (due.size() > 0 && due[0].t == cyc) begin
                e_wdata = due[0].d;
                void'(due.pop_front());
            end
            if (bus.rd_req) begin
                e_addr = bus.rd_addr;
                e_we   = 1'b0;
            end else if (q.size() > 0) begin
                h = q.pop_front();
                e_addr = h.a;
                e_we   = 1'b1;
                due.push_back('{cyc + 2, h.d});
            end else begin
                e_we = 1'b0;
            end
            if (p) begin
                if (q.size() < 4)
                    q.push_back('{proc_pix_addr, two_proc_pixs});
                else
                    e_ovf = 1'b1;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (run) begin
            if (reset) begin
                chk("rst_addr", 64'(bus.mem_addr), 64'd0);
                chk("rst_we", 64'(bus.mem_we), 64'd0);
                chk("rst_wdata", 64'(bus.mem_write_data), 64'd0);
                chk("rst_level", 64'(fifo_level), 64'd0);
                chk("rst_ovf", 64'(overflow), 64'd0);
            end else begin
                chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
                chk("mem_we", 64'(bus.mem_we), 64'(e_we));
                chk("mem_wdata", 64'(bus.mem_write_data), 64'(e_wdata));
                chk("fifo_level", 64'(fifo_level), 64'(q.size()));
                chk("overflow", 64'(overflow), 64'(e_ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [18:0] base);
        bus.rd_req = 1'b1;
        bus.rd_addr = 19'h7ABCD;
        wr_enable = 1'b1;
        vcount = 10'd20;
        for (int i = 1; i <= n; i++) begin
            hcount = 11'(i);
            proc_pix_addr = base + 19'(i);
            two_proc_pixs = {17'h0, base} + 36'(i) + 36'h111110000;
            tick();
        end
    endtask

    task automatic drain4(input logic [18:0] base);
        bus.rd_req = 1'b0;
        wr_enable = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("drain_we", 64'(bus.mem_we), 64'd1);
            chk("drain_addr", 64'(bus.mem_addr), 64'(base + 19'(2 * k + 1)));
            tick();
        end
        chk("drain_idle", 64'(bus.mem_we), 64'd0);
        repeat (4) tick();
    endtask

    int lvl;

    initial begin
        reset = 1'b1;
        hcount = '0;
        vcount = '0;
        two_proc_pixs = '0;
        proc_pix_addr = '0;
        wr_enable = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_we", 64'(bus.mem_we), 64'd0);

        // single write
        wr_enable = 1'b1;
        hcount = 11'd5;
        vcount = 10'd10;
        proc_pix_addr = 19'h01402;
        two_proc_pixs = 36'hABCDE1234;
        tick();
        hcount = 11'd6;
        chk("single_lvl", 64'(fifo_level), 64'd1);
        chk("single_we_early", 64'(bus.mem_we), 64'd0);
        tick();
        wr_enable = 1'b0;
        chk("single_we", 64'(bus.mem_we), 64'd1);
        chk("single_addr", 64'(bus.mem_addr), 64'h01402);
        tick();
        tick();
        chk("single_data", 64'(bus.mem_write_data), 64'hABCDE1234);

        // read priority
        fill(8, 19'h00100);
        chk("prio_lvl", 64'(fifo_level), 64'd4);
        chk("prio_addr", 64'(bus.mem_addr), 64'h7ABCD);
        chk("prio_we", 64'(bus.mem_we), 64'd0);
        drain4(19'h00100);

        // overflow
        fill(10, 19'h00200);
        chk("ovf_lvl", 64'(fifo_level), 64'd4);
        chk("ovf_flag", 64'(overflow), 64'd1);
        drain4(19'h00200);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // push and pop together at full
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        fill(8, 19'h00300);
        bus.rd_req = 1'b0;
        hcount = 11'd9;
        proc_pix_addr = 19'h00309;
        two_proc_pixs = 36'h999990309;
        tick();
        wr_enable = 1'b0;
        hcount = 11'd10;
        chk("full_pp_lvl", 64'(fifo_level), 64'd4);
        chk("full_pp_ovf", 64'(overflow), 64'd0);
        chk("full_pp_addr", 64'(bus.mem_addr), 64'h00301);
        repeat (8) tick();

        // capture gating
        bus.rd_req = 1'b1;
        lvl = 0;
        for (int i = 0; i < 6; i++) begin
            logic        w;
            logic [10:0] h;
            logic [9:0]  v;
            int          inc;
            unique case (i)
                0: begin w = 1; h = 11'd4;    v = 10'd10;  inc = 0; end
                1: begin w = 1; h = 11'd1025; v = 10'd10;  inc = 0; end
                2: begin w = 1; h = 11'd1023; v = 10'd768; inc = 0; end
                3: begin w = 0; h = 11'd3;    v = 10'd10;  inc = 0; end
                4: begin w = 1; h = 11'd2047; v = 10'd1023; inc = 0; end
                default: begin w = 1; h = 11'd1023; v = 10'd767; inc = 1; end
            endcase
            wr_enable = w;
            hcount = h;
            vcount = v;
            proc_pix_addr = 19'h00500 + 19'(i);
            two_proc_pixs = 36'h5555_0000 + 36'(i);
            tick();
            lvl += inc;
            chk("gate_lvl", 64'(fifo_level), 64'(lvl));
        end
        wr_enable = 1'b0;
        bus.rd_req = 1'b0;
        repeat (5) tick();

        // reset mid-burst with 3 entries queued
        fill(6, 19'h00400);
        chk("mid_lvl", 64'(fifo_level), 64'd3);
        wr_enable = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_addr", 64'(bus.mem_addr), 64'd0);
        chk("mid_we", 64'(bus.mem_we), 64'd0);
        chk("mid_wdata", 64'(bus.mem_write_data), 64'd0);
        chk("mid_level", 64'(fifo_level), 64'd0);
        chk("mid_ovf", 64'(overflow), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        bus.rd_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_write", 64'(bus.mem_we), 64'd0);
        end

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
